clk_gen_multi: RTL and testbench

- Parametrised multi-channel clock and tick generator; successor to the single fixed-ratio divider.
- Each channel divides clk_in by a runtime-programmable divisor and produces either a 50%-duty divided clock (toggle mode) or a one-cycle strobe (tick mode).
- Serves the ATM controller's display-scan, keypad-debounce and timeout timebases from one block.
- Divisor updates are glitch-free: they take effect only at a terminal count.

---
 rtl/clk_gen_pkg.sv | 7 +
 rtl/clk_gen_channel.sv | 51 +++++
 rtl/clk_gen_multi.sv | 60 ++++++
 tb/tb_clk_gen_multi.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared mode encodings and channel limits for clk_gen_multi.
package clk_gen_pkg;
   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_TICK = 1'b1;
   localparam int CH_IDX_W = 3;
   localparam int MAX_CH = 8;
endpackage

// File: rtl/clk_gen_channel.sv
// clk_gen_channel: one divider channel with shadowed divisor/mode, toggle or tick output.
module clk_gen_channel
   import clk_gen_pkg::*;
#(
   parameter int DIV_W = 25,
   parameter int DEF_DIV = 625000,
   parameter bit DEF_MODE = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wr_div_i,
   input  logic             wr_mode_i,
   output logic             clk_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, sdiv_q, sdiv_d;
   logic mode_q, mode_d, smode_q, smode_d, out_q, out_d, tc, load;
   // A write in the same cycle as a load point is forwarded straight into the active set
   always_comb begin
      sdiv_d = wr_i ? wr_div_i : sdiv_q;
      smode_d = wr_i ? wr_mode_i : smode_q;
      tc = en_i && (cnt_q == div_q);
      load = !en_i || tc || sync_i;
      div_d = load ? sdiv_d : div_q;
      mode_d = load ? smode_d : mode_q;
      cnt_d = load ? '0 : cnt_q + DIV_W'(1);
      out_d = (!en_i || sync_i || (tc && mode_d != mode_q)) ? 1'b0 :
              tc ? ((mode_q == MODE_TICK) ? 1'b1 : !out_q) :
              ((mode_q == MODE_TICK) ? 1'b0 : out_q);
   end
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         div_q <= DIV_W'(DEF_DIV);
         sdiv_q <= DIV_W'(DEF_DIV);
         mode_q <= DEF_MODE;
         smode_q <= DEF_MODE;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
         sdiv_q <= sdiv_d;
         mode_q <= mode_d;
         smode_q <= smode_d;
         out_q <= out_d;
      end
   end
   assign clk_o = out_q;
endmodule

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: N_CH programmable clock/tick channels with write decode and ack/err.
// Optional CLK_GEN_SYNC_EN adds sync_req to phase-align all enabled channels.
module clk_gen_multi
   import clk_gen_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int DIV_W = 25,
   parameter int DEF_DIV = 625000,
   parameter bit DEF_MODE = 1'b0
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic [N_CH-1:0]     ch_en,
`ifdef CLK_GEN_SYNC_EN
   input  logic                sync_req,
`endif
   input  logic                wr_en,
   input  logic [CH_IDX_W-1:0] wr_ch,
   input  logic [DIV_W-1:0]    wr_div,
   input  logic                wr_mode,
   output logic                wr_ack,
   output logic                wr_err,
   output logic [N_CH-1:0]     clk_out
);
   localparam logic [CH_IDX_W:0] N_CH_L = (CH_IDX_W+1)'(N_CH);
   logic sync, wr_ok, wr_ack_q, wr_err_q;
`ifdef CLK_GEN_SYNC_EN
   assign sync = sync_req;
`else
   assign sync = 1'b0;
`endif
   assign wr_ok = {1'b0, wr_ch} < N_CH_L;
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         wr_ack_q <= wr_en && wr_ok;
         wr_err_q <= wr_en && !wr_ok;
      end
   end
   assign wr_ack = wr_ack_q;
   assign wr_err = wr_err_q;
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      clk_gen_channel #(
         .DIV_W(DIV_W),
         .DEF_DIV(DEF_DIV),
         .DEF_MODE(DEF_MODE)
      ) u_ch (
         .clk_in(clk_in),
         .rst(rst),
         .en_i(ch_en[c]),
         .sync_i(sync),
         .wr_i(wr_en && (wr_ch == CH_IDX_W'(c))),
         .wr_div_i(wr_div),
         .wr_mode_i(wr_mode),
         .clk_o(clk_out[c])
      );
   end
endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: directed bench with a cycles-to-terminal-count reference model.
module tb_clk_gen_multi;
   localparam int NC = 4;
   localparam int DW = 25;
   logic clk_in = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_mode = 1'b0, sync_req = 1'b0;
   logic [NC-1:0] ch_en = '0;
   logic [2:0] wr_ch = '0;
   logic [DW-1:0] wr_div = '0;
   logic wr_ack, wr_err;
   logic [NC-1:0] clk_out;
   int n_chk = 0, n_fail = 0, cyc = 0, rel = 0;
   int m_div[NC], m_sdiv[NC], m_left[NC], rise_cyc[NC], rise_prev[NC];
   logic m_mode[NC], m_smode[NC];
   logic [NC-1:0] m_out;
   logic e_ack, e_err;

   always #5 clk_in = ~clk_in;

   clk_gen_multi #(.N_CH(NC), .DIV_W(DW), .DEF_DIV(4), .DEF_MODE(1'b0)) dut (
      .clk_in(clk_in),
      .rst(rst),
      .ch_en(ch_en),
`ifdef CLK_GEN_SYNC_EN
      .sync_req(sync_req),
`endif
      .wr_en(wr_en),
      .wr_ch(wr_ch),
      .wr_div(wr_div),
      .wr_mode(wr_mode),
      .wr_ack(wr_ack),
      .wr_err(wr_err),
      .clk_out(clk_out)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Reference model: m_left counts cycles remaining until the next terminal count
   initial begin
      for (int i = 0; i < NC; i++) begin
         rise_cyc[i] = 0;
         rise_prev[i] = 0;
      end
      forever begin
         @(posedge clk_in or posedge rst);
         if (rst) begin
            for (int i = 0; i < NC; i++) begin
               m_div[i] = 4; m_sdiv[i] = 4; m_left[i] = 4;
               m_mode[i] = 1'b0; m_smode[i] = 1'b0;
            end
            m_out = '0; e_ack = 1'b0; e_err = 1'b0;
            if (clk_in) cyc++;
         end else begin
            logic s;
            cyc++;
`ifdef CLK_GEN_SYNC_EN
            s = sync_req;
`else
            s = 1'b0;
`endif
            e_ack = wr_en && (wr_ch < 3'd4);
            e_err = wr_en && (wr_ch >= 3'd4);
            for (int i = 0; i < NC; i++) begin
               logic old_mode, old_out;
               old_mode = m_mode[i];
               old_out = m_out[i];
               if (wr_en && wr_ch == 3'(i)) begin
                  m_sdiv[i] = int'(wr_div);
                  m_smode[i] = wr_mode;
               end
               if (!ch_en[i] || s || m_left[i] == 0) begin
                  m_div[i] = m_sdiv[i];
                  m_mode[i] = m_smode[i];
                  m_left[i] = m_div[i];
                  if (!ch_en[i] || s || m_mode[i] != old_mode) m_out[i] = 1'b0;
                  else m_out[i] = m_mode[i] ? 1'b1 : !old_out;
               end else begin
                  m_left[i]--;
                  if (m_mode[i]) m_out[i] = 1'b0;
               end
               if (m_out[i] && !old_out) begin
                  rise_prev[i] = rise_cyc[i];
                  rise_cyc[i] = cyc;
               end
            end
            #1;
            if (!rst) begin
               chk("clk_out", int'(clk_out), int'(m_out));
               chk("wr_ack", int'(wr_ack), int'(e_ack));
               chk("wr_err", int'(wr_err), int'(e_err));
            end
         end
      end
   end

   task automatic write(input int ch, input int dv, input logic md);
      wr_en = 1'b1; wr_ch = 3'(ch); wr_div = DW'(dv); wr_mode = md;
      @(negedge clk_in);
      wr_en = 1'b0;
   endtask

   initial begin
      int t;
      cycles(3);
      ch_en = '1; rst = 1'b0; rel = cyc;
      cycles(6);
      chk("first_rise_ch0", rise_cyc[0] - rel, 5);
      chk("first_rise_ch3", rise_cyc[3] - rel, 5);
      cycles(18);
      chk("toggle_period_ch0", rise_cyc[0] - rise_prev[0], 10);
      write(1, 2, 1'b1);
      chk("ack_literal", int'(wr_ack), 1);
      cycles(20);
      chk("tick_period_ch1", rise_cyc[1] - rise_prev[1], 3);
      chk("ch0_unchanged", rise_cyc[0] - rise_prev[0], 10);
      write(5, 7, 1'b1);
      chk("err_literal", int'(wr_err), 1);
      chk("err_no_ack", int'(wr_ack), 0);
      ch_en = 4'b1011;
      cycles(7);
      chk("disabled_ch2_low", int'(clk_out[2]), 0);
      ch_en = '1; t = cyc;
      cycles(6);
      chk("reenable_rise_ch2", rise_cyc[2] - t, 5);
      write(0, 0, 1'b0);
      cycles(14);
      chk("div0_toggle_ch0", rise_cyc[0] - rise_prev[0], 2);
      write(0, 0, 1'b1);
      cycles(6);
      for (int k = 0; k < 3; k++) begin
         chk("div0_tick_const", int'(clk_out[0]), 1);
         cycles(1);
      end
      cycles(3);
      rst = 1'b1;
      #1;
      chk("rst_outputs_low", int'(clk_out), 0);
      @(negedge clk_in);
      rst = 1'b0; rel = cyc;
      cycles(6);
      chk("post_rst_rise_ch1", rise_cyc[1] - rel, 5);
      chk("post_rst_rise_ch0", rise_cyc[0] - rel, 5);
`ifdef CLK_GEN_SYNC_EN
      ch_en = 4'b0111;
      cycles(2);
      ch_en = '1;
      cycles(3);
      sync_req = 1'b1;
      @(negedge clk_in);
      sync_req = 1'b0;
      cycles(12);
      for (int i = 1; i < NC; i++) chk("sync_aligned", rise_cyc[i], rise_cyc[0]);
`endif
      cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
